// File: rtl/lcd_pkg.sv
// Shared timing constants and types for the DE-only LCD link,
// used by both the transmitter and the receiver.
package lcd_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_BLANK  = 160;
  localparam int V_BLANK  = 45;
  localparam int COLOR_W  = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/lcd_de_gap_detect.sv
// Edge and gap detector on registered DE: reports rise/fall and flags a DE-low
// run reaching VB_THRESH cycles as vertical blanking.
module lcd_de_gap_detect #(
  parameter int VB_THRESH = 480
) (
  input  logic pixel_clk,
  input  logic rst,
  input  logic de_q_i,
  output logic vb_hit_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              LO_W    = $clog2(VB_THRESH + 1);
  localparam logic [LO_W-1:0] LO_SAT  = LO_W'(VB_THRESH);
  localparam logic [LO_W-1:0] LO_LAST = LO_W'(VB_THRESH - 1);

  logic [LO_W-1:0] lo_cnt_q;
  logic [LO_W-1:0] lo_cnt_d;
  logic            de_prev_q;

  always_comb begin
    lo_cnt_d = lo_cnt_q;
    if (de_q_i) begin
      lo_cnt_d = '0;
    end else if (lo_cnt_q != LO_SAT) begin
      lo_cnt_d = lo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      lo_cnt_q  <= '0;
      de_prev_q <= 1'b0;
    end else begin
      lo_cnt_q  <= lo_cnt_d;
      de_prev_q <= de_q_i;
    end
  end

  // Saturation past VB_THRESH keeps this to a single pulse per blanking gap.
  assign vb_hit_o = !de_q_i && (lo_cnt_q == LO_LAST);
  assign rise_o   = de_q_i && !de_prev_q;
  assign fall_o   = !de_q_i && de_prev_q;

endmodule

// File: rtl/lcd_de_rx.sv
// DE-only parallel RGB receiver: recovers frame alignment from long DE-low gaps,
// rebuilds pixel coordinates, measures line/frame geometry and tracks lock.
module lcd_de_rx #(
  parameter int H_ACTIVE    = lcd_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = lcd_pkg::V_ACTIVE,
  parameter int VB_THRESH   = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int COLOR_W     = lcd_pkg::COLOR_W
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 de_in,
  input  logic [COLOR_W-1:0]   r_in,
  input  logic [COLOR_W-1:0]   g_in,
  input  logic [COLOR_W-1:0]   b_in,
  output logic                 pix_valid,
  output logic [9:0]           pix_x,
  output logic [9:0]           pix_y,
  output logic [3*COLOR_W-1:0] pix_rgb,
  output logic                 sof,
  output logic                 eol,
  output logic                 locked,
  output logic                 line_len_err,
  output logic                 frame_err,
  output logic [10:0]          meas_width,
  output logic [9:0]           meas_height,
  output logic [15:0]          frame_cnt
);

  import lcd_pkg::*;

  localparam int                GOOD_W   = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);
  localparam logic [10:0]       H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0]       H_LAST_W = 11'(H_ACTIVE - 1);
  localparam logic [9:0]        V_ACT_W  = 10'(V_ACTIVE);
  localparam logic [10:0]       X_MAX    = 11'd2047;
  localparam logic [9:0]        Y_MAX    = 10'd1023;

  logic                 de_q;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 vb_hit, rise, fall;

  rx_state_t            state_q, state_d, state_eff;
  logic [10:0]          x_q, x_d;
  logic [9:0]           y_q, y_d;
  logic                 line_bad_q, line_bad_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
  logic [10:0]          meas_width_q, meas_width_d;
  logic [9:0]           meas_height_q, meas_height_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 locked_q, locked_d;
  logic                 line_len_err_q, line_len_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 sof_q, sof_d;
  logic                 eol_q, eol_d;
  logic [9:0]           pix_x_q, pix_y_q;
  logic [3*COLOR_W-1:0] pix_rgb_q;

  lcd_de_gap_detect #(
    .VB_THRESH (VB_THRESH)
  ) u_gap (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .de_q_i    (de_q),
    .vb_hit_o  (vb_hit),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  always_comb begin
    // The rising-edge pixel that leaves ARMED is already the first active pixel.
    state_eff = state_q;
    if (state_q == ARMED && rise) begin
      state_eff = ACTIVE;
    end
    state_d        = state_eff;
    x_d            = x_q;
    y_d            = y_q;
    line_bad_d     = line_bad_q;
    good_cnt_d     = good_cnt_q;
    meas_width_d   = meas_width_q;
    meas_height_d  = meas_height_q;
    frame_cnt_d    = frame_cnt_q;
    line_len_err_d = 1'b0;
    frame_err_d    = 1'b0;

    if (state_eff == ACTIVE) begin
      if (de_q) begin
        if (x_q != X_MAX) x_d = x_q + 1'b1;
      end else if (fall) begin
        meas_width_d = x_q;
        x_d          = '0;
        if (x_q != H_ACT_W) begin
          line_len_err_d = 1'b1;
          line_bad_d     = 1'b1;
          good_cnt_d     = '0;
        end
        if (y_q != Y_MAX) y_d = y_q + 1'b1;
      end else if (vb_hit) begin
        meas_height_d = y_q;
        state_d       = ARMED;
        x_d           = '0;
        y_d           = '0;
        line_bad_d    = 1'b0;
        if (y_q != V_ACT_W || line_bad_q) begin
          frame_err_d = 1'b1;
          good_cnt_d  = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + 1'b1;
        end
      end
    end else begin
      x_d        = '0;
      y_d        = '0;
      line_bad_d = 1'b0;
      if (state_eff == SEARCH && vb_hit) state_d = ARMED;
    end

    locked_d    = (good_cnt_d == GOOD_MAX);
    pix_valid_d = de_q && (state_eff == ACTIVE) && (x_q < H_ACT_W) && (y_q < V_ACT_W);
    sof_d       = pix_valid_d && (x_q == '0) && (y_q == '0);
    eol_d       = pix_valid_d && (x_q == H_LAST_W);
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      de_q           <= 1'b0;
      rgb_q          <= '0;
      state_q        <= SEARCH;
      x_q            <= '0;
      y_q            <= '0;
      line_bad_q     <= 1'b0;
      good_cnt_q     <= '0;
      meas_width_q   <= '0;
      meas_height_q  <= '0;
      frame_cnt_q    <= '0;
      locked_q       <= 1'b0;
      line_len_err_q <= 1'b0;
      frame_err_q    <= 1'b0;
      pix_valid_q    <= 1'b0;
      sof_q          <= 1'b0;
      eol_q          <= 1'b0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      pix_rgb_q      <= '0;
    end else begin
      de_q           <= de_in;
      rgb_q          <= {r_in, g_in, b_in};
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      line_bad_q     <= line_bad_d;
      good_cnt_q     <= good_cnt_d;
      meas_width_q   <= meas_width_d;
      meas_height_q  <= meas_height_d;
      frame_cnt_q    <= frame_cnt_d;
      locked_q       <= locked_d;
      line_len_err_q <= line_len_err_d;
      frame_err_q    <= frame_err_d;
      pix_valid_q    <= pix_valid_d;
      sof_q          <= sof_d;
      eol_q          <= eol_d;
      pix_x_q        <= x_q[9:0];
      pix_y_q        <= y_q;
      pix_rgb_q      <= rgb_q;
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_rgb      = pix_rgb_q;
  assign sof          = sof_q;
  assign eol          = eol_q;
  assign locked       = locked_q;
  assign line_len_err = line_len_err_q;
  assign frame_err    = frame_err_q;
  assign meas_width   = meas_width_q;
  assign meas_height  = meas_height_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_lcd_de_rx.sv
// Directed bench for lcd_de_rx on a scaled frame (16x8 active pixels) that keeps
// the real 160-cycle horizontal blank and 480-cycle vertical-blank threshold.
module tb_lcd_de_rx;
  import lcd_pkg::*;

  localparam int H        = 16;
  localparam int V        = 8;
  localparam int HB       = 160;
  localparam int VB_LINES = 3;
  localparam int CW       = 8;

  logic            pixel_clk = 1'b0;
  logic            rst = 1'b1;
  logic            de_in = 1'b0;
  logic [CW-1:0]   r_in = '0;
  logic [CW-1:0]   g_in = '0;
  logic [CW-1:0]   b_in = '0;
  logic            pix_valid, sof, eol, locked, line_len_err, frame_err;
  logic [9:0]      pix_x, pix_y, meas_height;
  logic [10:0]     meas_width;
  logic [15:0]     frame_cnt;
  logic [3*CW-1:0] pix_rgb;

  lcd_de_rx #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .VB_THRESH   (480),
    .LOCK_FRAMES (2),
    .COLOR_W     (CW)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .de_in        (de_in),
    .r_in         (r_in),
    .g_in         (g_in),
    .b_in         (b_in),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_rgb      (pix_rgb),
    .sof          (sof),
    .eol          (eol),
    .locked       (locked),
    .line_len_err (line_len_err),
    .frame_err    (frame_err),
    .meas_width   (meas_width),
    .meas_height  (meas_height),
    .frame_cnt    (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Per-segment observations gathered cycle by cycle.
  int   n_valid, n_sof, n_eol, n_lerr, n_ferr, n_vb, pix_bad, fstep, sof_step, lerr_w;
  logic lerr_lock, lerr_lock_before;
  logic locked_prev = 1'b0;
  logic prev_de = 1'b0;
  int   prev_x = 0;
  int   prev_y = 0;
  logic [3*CW-1:0] prev_rgb = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_valid = 0; n_sof = 0; n_eol = 0; n_lerr = 0; n_ferr = 0; n_vb = 0;
    pix_bad = 0; fstep = 0; sof_step = -1; lerr_w = -1;
    lerr_lock = 1'bx; lerr_lock_before = 1'bx;
  endtask

  // Drive one cycle, then sample outputs, which belong to the input of the previous step.
  task automatic step(input logic de, input int x, input int y);
    rgb_t px;
    px.r = 8'(x);
    px.g = 8'(y);
    px.b = 8'(x + 3 * y + 1);
    de_in = de;
    {r_in, g_in, b_in} = px;
    @(posedge pixel_clk);
    #1;
    if (pix_valid) begin
      n_valid++;
      if (!prev_de || prev_x >= H || prev_y >= V || pix_x != 10'(prev_x) ||
          pix_y != 10'(prev_y) || pix_rgb != prev_rgb) pix_bad++;
    end
    if (sof) begin
      n_sof++;
      sof_step = fstep;
      if (!(pix_valid && prev_x == 0 && prev_y == 0)) pix_bad++;
    end
    if (eol) begin
      n_eol++;
      if (!(pix_valid && prev_x == H - 1)) pix_bad++;
    end
    if (line_len_err) begin
      n_lerr++;
      lerr_w = int'(meas_width);
      lerr_lock = locked;
      lerr_lock_before = locked_prev;
    end
    if (frame_err) n_ferr++;
    if (dut.u_gap.vb_hit_o) n_vb++;
    locked_prev = locked;
    fstep++;
    prev_de = de; prev_x = x; prev_y = y; prev_rgb = px;
  endtask

  task automatic send_line(input int y, input int len);
    for (int x = 0; x < len; x++) step(1'b1, x, y);
  endtask

  task automatic send_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len);
    clr();
    for (int y = 0; y < nlines; y++) begin
      send_line(y, (y == bad_line) ? bad_len : H);
      send_low(HB);
    end
    send_low(VB_LINES * (H + HB));
  endtask

  task automatic chk_frame(input string tag, input int e_valid, input int e_sof, input int e_eol,
                           input int e_lerr, input int e_ferr, input int e_fcnt, input logic e_lock);
    chk({tag, "_valid"}, n_valid, e_valid);
    chk({tag, "_sof"}, n_sof, e_sof);
    chk({tag, "_eol"}, n_eol, e_eol);
    chk({tag, "_pixdata"}, pix_bad, 0);
    chk({tag, "_lerr"}, n_lerr, e_lerr);
    chk({tag, "_ferr"}, n_ferr, e_ferr);
    chk({tag, "_fcnt"}, frame_cnt, e_fcnt);
    chk({tag, "_locked"}, locked, e_lock);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    de_in = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_sof", sof, 0);
    chk("rst_eol", eol, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lerr", line_len_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_meas_width", meas_width, 0);
    chk("rst_meas_height", meas_height, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_pix_rgb", pix_rgb, 0);
    chk("rst_state", dut.state_q, SEARCH);
    rst = 1'b0;

    // Gap threshold: runs of 160 and 479 do not mark vblank, 480 does
    clr();
    send_line(0, 4);
    send_low(160);
    send_line(0, 4);
    send_low(479);
    step(1'b1, 0, 0);
    chk("gap_479_vb", n_vb, 0);
    chk("gap_479_state", dut.state_q, SEARCH);
    send_low(480);
    step(1'b1, 0, 0);
    chk("gap_480_vb", n_vb, 1);
    chk("gap_480_state", dut.state_q, ARMED);
    step(1'b1, 1, 0);
    chk("gap_rise_state", dut.state_q, ACTIVE);

    // Nominal stream
    do_reset();
    send_frame(V, -1, 0);
    chk_frame("f0", 0, 0, 0, 0, 0, 0, 1'b0);
    chk("f0_state", dut.state_q, ARMED);
    send_frame(V, -1, 0);
    chk_frame("f1", H * V, 1, V, 0, 0, 1, 1'b0);
    chk("f1_sof_latency", sof_step, 1);
    chk("f1_meas_width", meas_width, H);
    chk("f1_meas_height", meas_height, V);
    send_frame(V, -1, 0);
    chk_frame("f2", H * V, 1, V, 0, 0, 2, 1'b1);

    // Short line in a locked frame, then relock
    send_frame(V, 3, H - 1);
    chk_frame("short_line", H * V - 1, 1, V - 1, 1, 1, 2, 1'b0);
    chk("short_line_width", lerr_w, H - 1);
    chk("short_line_lock_before", lerr_lock_before, 1);
    chk("short_line_lock_at_pulse", lerr_lock, 0);
    send_frame(V, -1, 0);
    chk_frame("relock1", H * V, 1, V, 0, 0, 3, 1'b0);
    send_frame(V, -1, 0);
    chk_frame("relock2", H * V, 1, V, 0, 0, 4, 1'b1);

    // Short frame
    send_frame(V - 1, -1, 0);
    chk_frame("short_frame", H * (V - 1), 1, V - 1, 0, 1, 4, 1'b0);
    chk("short_frame_height", meas_height, V - 1);

    // Long line: overflow pixels dropped but measured
    send_frame(V, 2, H + 10);
    chk_frame("long_line", H * V, 1, V, 1, 1, 4, 1'b0);
    chk("long_line_width", lerr_w, H + 10);
    send_frame(V, -1, 0);
    chk_frame("relock3", H * V, 1, V, 0, 0, 5, 1'b0);
    send_frame(V, -1, 0);
    chk_frame("relock4", H * V, 1, V, 0, 0, 6, 1'b1);

    // Asynchronous reset in the middle of line 5 of a locked stream
    clr();
    for (int y = 0; y < 5; y++) begin
      send_line(y, H);
      send_low(HB);
    end
    send_line(5, H / 2);
    chk("pre_rst_valid", pix_valid, 1);
    chk("pre_rst_locked", locked, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", pix_valid, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    chk("async_rst_meas_width", meas_width, 0);
    chk("async_rst_meas_height", meas_height, 0);
    chk("async_rst_pix_x", pix_x, 0);
    chk("async_rst_state", dut.state_q, SEARCH);
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    clr();
    for (int x = H / 2; x < H; x++) step(1'b1, x, 5);
    send_low(HB);
    for (int y = 6; y < V; y++) begin
      send_line(y, H);
      send_low(HB);
    end
    send_low(VB_LINES * (H + HB));
    chk_frame("rst_remainder", 0, 0, 0, 0, 0, 0, 1'b0);
    chk("rst_remainder_state", dut.state_q, ARMED);
    send_frame(V, -1, 0);
    chk_frame("post_rst", H * V, 1, V, 0, 0, 1, 1'b0);
    chk("post_rst_sof_latency", sof_step, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
